// File: rtl/j_serial_collect_mx_cell.sv
// Deserialises 32 MSB-first bit-serial lanes into words, buffers one word per lane,
// and drains them round-robin onto a valid/ready write stream with per-lane addresses.
module j_serial_collect_mx_cell #(
   parameter int NUM_LANES  = 32,
   parameter int DATA_W     = 32,
   parameter int SRAM_DEPTH = 262144,
   parameter int ADDR_W     = $clog2(SRAM_DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        collect_start,
   input  logic [ADDR_W*NUM_LANES-1:0] base_addr,
   input  logic [NUM_LANES-1:0]        serial_output,
   input  logic [NUM_LANES-1:0]        serial_en,
   input  logic [NUM_LANES-1:0]        serial_start,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [DATA_W-1:0]           out_data,
   output logic [ADDR_W-1:0]           out_addr,
   output logic [4:0]                  out_lane,
   output logic                        overflow,
   output logic                        collect_idle
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic {IDLE, SHIFT} lane_state_t;

   lane_state_t          state    [NUM_LANES];
   logic [DATA_W-1:0]    shreg    [NUM_LANES];
   logic [CNT_W-1:0]     cnt      [NUM_LANES];
   logic [DATA_W-1:0]    buf_dat  [NUM_LANES];
   logic [ADDR_W-1:0]    word_idx [NUM_LANES];
   logic [ADDR_W-1:0]    base_r   [NUM_LANES];
   logic [DATA_W-1:0]    done_word[NUM_LANES];
   logic [NUM_LANES-1:0] buf_vld;
   logic [NUM_LANES-1:0] done;
   logic [NUM_LANES-1:0] drain;
   logic [NUM_LANES-1:0] shifting;
   logic [4:0]           ptr;
   logic [4:0]           grant;
   logic [4:0]           idx;
   logic                 grant_vld;
   logic                 load;
   logic                 ovf_evt;

   always_comb begin
      done     = '0;
      shifting = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         done_word[l] = {shreg[l][DATA_W-2:0], serial_output[l]};
         shifting[l]  = (state[l] == SHIFT);
         done[l]      = (state[l] == SHIFT) && serial_en[l] && !serial_start[l] &&
                        (cnt[l] == CNT_W'(DATA_W - 1));
      end
   end

   // First buffered lane at or after the pointer, wrapping past the top lane.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      idx       = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         idx = 5'((int'(ptr) + i) % NUM_LANES);
         if (!grant_vld && buf_vld[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   assign load         = !out_valid || out_ready;
   assign drain        = (load && grant_vld) ? (NUM_LANES'(1) << grant) : '0;
   assign ovf_evt      = |(done & buf_vld & ~drain);
   assign collect_idle = !(|shifting) && !(|buf_vld) && !out_valid;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         buf_vld <= '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            state[l]    <= IDLE;
            shreg[l]    <= '0;
            cnt[l]      <= '0;
            buf_dat[l]  <= '0;
            word_idx[l] <= '0;
            base_r[l]   <= '0;
         end
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            // A start bit always begins a fresh word, discarding any partial one.
            if (serial_en[l]) begin
               if (serial_start[l]) begin
                  state[l] <= SHIFT;
                  shreg[l] <= DATA_W'(serial_output[l]);
                  cnt[l]   <= CNT_W'(1);
               end else if (state[l] == SHIFT) begin
                  shreg[l] <= done_word[l];
                  if (done[l]) begin
                     state[l] <= IDLE;
                     cnt[l]   <= '0;
                  end else begin
                     cnt[l] <= cnt[l] + CNT_W'(1);
                  end
               end
            end

            if (done[l] && !(buf_vld[l] && !drain[l])) begin
               buf_vld[l] <= 1'b1;
               buf_dat[l] <= done_word[l];
            end else if (drain[l]) begin
               buf_vld[l] <= 1'b0;
            end

            if (collect_start) begin
               word_idx[l] <= '0;
               base_r[l]   <= base_addr[l*ADDR_W +: ADDR_W];
            end else if (drain[l]) begin
               word_idx[l] <= word_idx[l] + ADDR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_lane  <= '0;
         overflow  <= 1'b0;
         ptr       <= '0;
      end else begin
         if (ovf_evt) begin
            overflow <= 1'b1;
         end else if (collect_start) begin
            overflow <= 1'b0;
         end

         if (load) begin
            if (grant_vld) begin
               out_valid <= 1'b1;
               out_data  <= buf_dat[grant];
               out_lane  <= grant;
               out_addr  <= base_r[grant] + word_idx[grant];
               ptr       <= (grant == 5'(NUM_LANES - 1)) ? 5'd0 : grant + 5'd1;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule
